// File: rtl/transpose_down_if.sv
// Sample strobe, rate control and status bundle for the pitch-down transposer.
interface transpose_down_if #(
  parameter int W      = 16,
  parameter int FRAC_W = 8
);
  logic                sample_strobe;
  logic signed [W-1:0] sample_in;
  logic [FRAC_W:0]     rate;
  logic signed [W-1:0] sample_out;
  logic                out_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output sample_strobe, sample_in, rate,
    input  sample_out, out_valid, busy, overrun
  );
  modport slave (
    input  sample_strobe, sample_in, rate,
    output sample_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/transpose_down.sv
// Pitch-down transposer: two cross-faded taps over a circular buffer, delays growing per sample.
// TRANSPOSE_DOWN_INTERP_EN enables linear tap interpolation (latency 7); otherwise floor taps (latency 5).
module transpose_down #(
  parameter int W      = 16,
  parameter int FRAC_W = 8,
  parameter int WINDOW = 256,
  parameter int ADDR_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  transpose_down_if.slave io
);
  localparam int LW = $clog2(WINDOW);
  localparam int DW = LW + FRAC_W;
  localparam int MW = W + LW + 1;
  localparam logic [FRAC_W:0] ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [LW-1:0]   HALF = LW'(WINDOW / 2);

`ifdef TRANSPOSE_DOWN_INTERP_EN
  localparam int PW = W + FRAC_W + 2;
  typedef enum logic [2:0] {IDLE, WR, RA0, RB0, RA1, RB1, MIX, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, RA0, RA1, MIX, DONE} state_t;
`endif

  state_t state, state_nx;

  logic signed [W-1:0]  mem [2**ADDR_W];
  logic signed [W-1:0]  rd_dat, smp, cap_a0, y0, y1, mix_q;
  logic [ADDR_W-1:0]    wr_ptr, rd_addr, addr_a0, addr_a1;
  logic [DW-1:0]        d;
  logic [FRAC_W:0]      rate_q, r;
  logic [LW-1:0]        t0, t1;
  logic                 primed;
  logic signed [MW-1:0] y0x, y1x, e0x, e1x, mix;

  // Triangular envelope; WINDOW-1-x is the bitwise complement for a power-of-two window.
  function automatic logic [LW-1:0] env(input logic [LW-1:0] x);
    return (x < ~x) ? x : ~x;
  endfunction

  assign r       = (rate_q > ONE) ? ONE : rate_q;
  assign t0      = d[DW-1:FRAC_W];
  assign t1      = t0 + HALF;
  assign addr_a0 = wr_ptr - ADDR_W'(t0);
  assign addr_a1 = wr_ptr - ADDR_W'(t1);

`ifdef TRANSPOSE_DOWN_INTERP_EN
  logic signed [W-1:0] cap_b0, cap_a1;
  logic [FRAC_W-1:0]   frac;
  logic [ADDR_W-1:0]   addr_b0, addr_b1;

  function automatic logic signed [W-1:0] lerp(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic [FRAC_W-1:0]   f);
    logic signed [PW-1:0] dx, fx;
    dx = PW'(b) - PW'(a);
    fx = PW'(f);
    return a + W'((dx * fx) >>> FRAC_W);
  endfunction

  assign frac    = d[FRAC_W-1:0];
  assign addr_b0 = addr_a0 - ADDR_W'(1);
  assign addr_b1 = addr_a1 - ADDR_W'(1);
  assign y0      = lerp(cap_a0, cap_b0, frac);
  assign y1      = lerp(cap_a1, rd_dat, frac);
`else
  assign y0 = cap_a0;
  assign y1 = rd_dat;
`endif

  assign y0x = MW'(y0);
  assign y1x = MW'(y1);
  assign e0x = MW'(env(t0));
  assign e1x = MW'(env(t1));
  assign mix = y0x * e0x + y1x * e1x;

  assign io.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_addr  = addr_a0;
    case (state)
      IDLE: if (io.sample_strobe) state_nx = WR;
      WR:   state_nx = RA0;
`ifdef TRANSPOSE_DOWN_INTERP_EN
      RA0:  begin rd_addr = addr_a0; state_nx = RB0; end
      RB0:  begin rd_addr = addr_b0; state_nx = RA1; end
      RA1:  begin rd_addr = addr_a1; state_nx = RB1; end
      RB1:  begin rd_addr = addr_b1; state_nx = MIX; end
`else
      RA0:  begin rd_addr = addr_a0; state_nx = RA1; end
      RA1:  begin rd_addr = addr_a1; state_nx = MIX; end
`endif
      MIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sample buffer is deliberately left unreset; priming masks its stale contents.
  always_ff @(posedge clk) begin
    if (state == WR) mem[wr_ptr] <= smp;
    rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d             <= '0;
      wr_ptr        <= '0;
      primed        <= 1'b0;
      smp           <= '0;
      rate_q        <= '0;
      cap_a0        <= '0;
`ifdef TRANSPOSE_DOWN_INTERP_EN
      cap_b0        <= '0;
      cap_a1        <= '0;
`endif
      mix_q         <= '0;
      io.sample_out <= '0;
      io.out_valid  <= 1'b0;
      io.overrun    <= 1'b0;
    end else begin
      io.out_valid <= 1'b0;
      if (io.sample_strobe) begin
        if (state == IDLE) begin
          smp    <= io.sample_in;
          rate_q <= io.rate;
        end else begin
          io.overrun <= 1'b1;
        end
      end
      case (state)
`ifdef TRANSPOSE_DOWN_INTERP_EN
        RB0: cap_a0 <= rd_dat;
        RA1: cap_b0 <= rd_dat;
        RB1: cap_a1 <= rd_dat;
`else
        RA1: cap_a0 <= rd_dat;
`endif
        MIX: mix_q <= W'(mix >>> (LW - 1));
        DONE: begin
          io.sample_out <= primed ? mix_q : '0;
          io.out_valid  <= 1'b1;
          d             <= d + DW'(ONE - r);
          wr_ptr        <= wr_ptr + ADDR_W'(1);
          if (&wr_ptr) primed <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_transpose_down.sv
// Scoreboard bench for transpose_down: random and directed stimulus against a buffer-level reference model.
module tb_transpose_down;
  localparam int W      = 16;
  localparam int FRAC_W = 8;
`ifdef TRANSPOSE_DOWN_INTERP_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif
  localparam int G = LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  transpose_down_if #(.W(W), .FRAC_W(FRAC_W)) io ();

  transpose_down #(.W(W), .FRAC_W(FRAC_W), .WINDOW(256), .ADDR_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     exp_q[$];
  longint expc_q[$];
  int     caps[$];
  int     caps_a[$];
  bit     cap_en = 1'b0;
  int     last_out = 0;
  int     vld_cnt = 0;

  // Reference model state: the buffer as written samples, delay in Q8, write index, primed flag.
  int mbuf[512];
  int md, mwp;
  bit mprimed;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    md = 0;
    mwp = 0;
    mprimed = 1'b0;
  endfunction

  function automatic int model(input int x, input int rt);
    int t[2];
    int y;
    int e;
    int ia, a, frac, acc, res;
`ifdef TRANSPOSE_DOWN_INTERP_EN
    int ib, b;
`endif
    mbuf[mwp] = x;
    frac = md % 256;
    t[0] = md / 256;
    t[1] = (t[0] + 128) % 256;
    acc = 0;
    for (int k = 0; k < 2; k++) begin
      ia = (mwp - t[k] + 512) % 512;
      a  = mbuf[ia];
`ifdef TRANSPOSE_DOWN_INTERP_EN
      ib = (ia + 511) % 512;
      b  = mbuf[ib];
      y  = a + (((b - a) * frac) >>> 8);
`else
      y  = a;
`endif
      e = (t[k] < 255 - t[k]) ? t[k] : 255 - t[k];
      acc += y * e;
    end
    res = mprimed ? (acc >>> 7) : 0;
    md  = (md + 256 - ((rt > 256) ? 256 : rt)) % 65536;
    mwp = (mwp + 1) % 512;
    if (mwp == 0) mprimed = 1'b1;
    return res;
  endfunction

  always @(negedge clk) begin : monitor
    int e;
    longint c;
    logic signed [15:0] got, want;
    if (io.out_valid === 1'b1) begin
      vld_cnt++;
      got = io.sample_out;
      last_out = int'(got);
      if (cap_en) caps.push_back(last_out);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got sample_out=%0d, required no output", got);
      end else begin
        e = exp_q.pop_front();
        c = expc_q.pop_front();
        want = 16'(e);
        if (got !== want) begin
          errors++;
          $display("FAIL sample_out: got %0d, required %0d", got, want);
        end
        checks++;
        if (cyc != c) begin
          errors++;
          $display("FAIL latency: out_valid at cycle %0d, required %0d", cyc, c);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic send(input int x, input int rt, input int gap);
    @(negedge clk);
    io.sample_in     = 16'(x);
    io.rate          = 9'(rt);
    io.sample_strobe = 1'b1;
    exp_q.push_back(model(x, rt));
    expc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    io.sample_strobe = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
      expc_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    io.sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int stim[700];
    int vb, mism, nz;
    io.sample_strobe = 1'b0;
    io.sample_in     = '0;
    io.rate          = 9'd256;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_sample_out", int'(io.sample_out), 0);
    chk("reset_out_valid", int'(io.out_valid), 0);
    chk("reset_busy", int'(io.busy), 0);
    chk("reset_overrun", int'(io.overrun), 0);
    rst = 1'b0;

    for (int i = 0; i < 511; i++) send(rnd_sample(), 256, 16);
    drain();
    chk("prime_out_zero", last_out, 0);
    send(rnd_sample(), 256, 16);
    drain();
    chk("primed_set", int'(dut.primed), 1);

    for (int i = 0; i < 300; i++) send(1000, 256, G);
    drain();
    chk("dc_unity_pos", last_out, 992);
    for (int i = 0; i < 300; i++) send(-1000, 256, G);
    drain();
    chk("dc_unity_neg", last_out, -993);

    for (int i = 0; i < 600; i++) send(1000, 128, G);
    drain();
    chk("octave_dc_wrap", last_out, 992);

    for (int i = 0; i < 300; i++) send((i % 2) ? 256 : 0, 128, G);
    drain();

    for (int i = 0; i < 400; i++) send(rnd_sample(), int'($urandom_range(0, 300)), G);
    drain();

    // Second strobe lands 3 clk after an accepted one and must be dropped.
    @(negedge clk);
    io.sample_in     = 16'(4321);
    io.rate          = 9'd200;
    io.sample_strobe = 1'b1;
    exp_q.push_back(model(4321, 200));
    expc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    io.sample_strobe = 1'b0;
    chk("busy_after_strobe", int'(io.busy), 1);
    chk("overrun_before", int'(io.overrun), 0);
    @(negedge clk);
    @(negedge clk);
    io.sample_in     = 16'(12345);
    io.sample_strobe = 1'b1;
    @(negedge clk);
    io.sample_strobe = 1'b0;
    drain();
    chk("overrun_set", int'(io.overrun), 1);
    send(rnd_sample(), 256, G);
    drain();
    chk("overrun_held", int'(io.overrun), 1);

    vb = vld_cnt;
    @(negedge clk);
    io.sample_in     = 16'(777);
    io.sample_strobe = 1'b1;
    @(negedge clk);
    io.sample_strobe = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("midrst_out_valid", int'(io.out_valid), 0);
    chk("midrst_sample_out", int'(io.sample_out), 0);
    chk("midrst_overrun", int'(io.overrun), 0);
    chk("midrst_busy", int'(io.busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", vld_cnt - vb, 0);

    for (int i = 0; i < 700; i++) stim[i] = rnd_sample();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      caps.delete();
      cap_en = 1'b1;
      for (int i = 0; i < 700; i++) send(stim[i], (pass == 0) ? 300 : 256, G);
      drain();
      cap_en = 1'b0;
      if (pass == 0) caps_a = caps;
    end
    chk("clamp_len", caps.size(), caps_a.size());
    mism = 0;
    nz = 0;
    for (int i = 0; i < caps.size() && i < caps_a.size(); i++) begin
      if (caps[i] != caps_a[i]) mism++;
      if (caps[i] != 0) nz++;
    end
    chk("clamp_stream_diffs", mism, 0);
    chk("clamp_nontrivial", int'(nz > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
